exception_ctrl: RTL and testbench

//   Consumer side of the CP0 register file. Samples status/cause/epc from CP0,

---
 rtl/exception_ctrl.sv | 164 ++++++++++++++++
 tb/tb_exception_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// MEM-stage exception/interrupt/ERET arbiter: drives a CP0 update strobe and a pipeline flush with redirect PC.
// Latency: event sampled in cycle N is visible in cycle N+1; flush held FLUSH_CYCLES, inputs ignored meanwhile.
module exception_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] status_input,
   input  logic [31:0] cause_input,
   input  logic [31:0] epc_input,
   input  logic        cp0_write_enable_input,
   input  logic [4:0]  cp0_write_address_input,
   input  logic [31:0] cp0_write_data_input,
   input  logic [4:0]  exception_flags_input,
   input  logic [31:0] current_inst_address_input,
   input  logic        is_in_delayslot_input,
   output logic        flush_output,
   output logic [31:0] new_pc_output,
   output logic        exc_commit_output,
   output logic [4:0]  exc_code_output,
   output logic [31:0] exc_epc_output,
   output logic        exc_bd_output,
   output logic        eret_output
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;
   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES);

   localparam logic [4:0] CODE_INT  = 5'h00;
   localparam logic [4:0] CODE_SYS  = 5'h08;
   localparam logic [4:0] CODE_RI   = 5'h0a;
   localparam logic [4:0] CODE_TRAP = 5'h0d;
   localparam logic [4:0] CODE_OV   = 5'h0c;

   logic [0:0]  state;
   logic [2:0]  flush_cnt;
   logic        int_pending;

   logic [31:0] st_fwd;
   logic [31:0] ca_fwd;
   logic [31:0] epc_fwd;
   logic        int_cond;
   logic        int_allowed;
   logic        int_req;
   logic        take;
   logic        take_int;
   logic        take_eret;
   logic [4:0]  sel_code;
   logic [31:0] epc_adj;
   logic        unused_bits;

   // Same-cycle MTC0 writes win over the registered CP0 values.
   always_comb begin
      st_fwd  = status_input;
      ca_fwd  = cause_input;
      epc_fwd = epc_input;
      if (cp0_write_enable_input) begin
         case (cp0_write_address_input)
            5'd12: st_fwd = cp0_write_data_input;
            5'd13: begin
               ca_fwd[9:8] = cp0_write_data_input[9:8];
               ca_fwd[23]  = cp0_write_data_input[23];
               ca_fwd[22]  = cp0_write_data_input[22];
            end
            5'd14: epc_fwd = cp0_write_data_input;
            default: ;
         endcase
      end
   end

   assign int_allowed = st_fwd[0] & ~st_fwd[1];
   assign int_cond    = int_allowed & (|(ca_fwd[15:8] & st_fwd[15:8]));
   assign int_req     = int_allowed & (int_pending | int_cond);
   assign epc_adj     = is_in_delayslot_input ? (current_inst_address_input - 32'd4)
                                              : current_inst_address_input;

   always_comb begin
      take      = 1'b0;
      take_int  = 1'b0;
      take_eret = 1'b0;
      sel_code  = CODE_INT;
      if (state == ST_IDLE && current_inst_address_input != 32'd0) begin
         take = 1'b1;
         if (int_req) begin
            take_int = 1'b1;
         end else if (exception_flags_input[0]) begin
            sel_code = CODE_SYS;
         end else if (exception_flags_input[1]) begin
            sel_code = CODE_RI;
         end else if (exception_flags_input[2]) begin
            sel_code = CODE_TRAP;
         end else if (exception_flags_input[3]) begin
            sel_code = CODE_OV;
         end else if (exception_flags_input[4]) begin
            take_eret = 1'b1;
         end else begin
            take = 1'b0;
         end
      end
   end

   // Pending is frozen during FLUSH and across bubbles unless IE/EXL forbid it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         int_pending <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (take_int || !int_allowed) begin
            int_pending <= 1'b0;
         end else if (int_cond) begin
            int_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state             <= ST_IDLE;
         flush_cnt         <= 3'd0;
         flush_output      <= 1'b0;
         new_pc_output     <= 32'd0;
         exc_commit_output <= 1'b0;
         exc_code_output   <= 5'd0;
         exc_epc_output    <= 32'd0;
         exc_bd_output     <= 1'b0;
         eret_output       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take) begin
                  state             <= ST_FLUSH;
                  flush_cnt         <= 3'd1;
                  flush_output      <= 1'b1;
                  new_pc_output     <= take_eret ? epc_fwd : EXC_VECTOR;
                  exc_commit_output <= 1'b1;
                  exc_code_output   <= take_eret ? 5'd0 : sel_code;
                  exc_epc_output    <= take_eret ? 32'd0 : epc_adj;
                  exc_bd_output     <= take_eret ? 1'b0 : is_in_delayslot_input;
                  eret_output       <= take_eret;
               end
            end
            default: begin
               exc_commit_output <= 1'b0;
               exc_code_output   <= 5'd0;
               exc_epc_output    <= 32'd0;
               exc_bd_output     <= 1'b0;
               eret_output       <= 1'b0;
               if (flush_cnt >= FLUSH_LAST) begin
                  state         <= ST_IDLE;
                  flush_cnt     <= 3'd0;
                  flush_output  <= 1'b0;
                  new_pc_output <= 32'd0;
               end else begin
                  flush_cnt <= flush_cnt + 3'd1;
               end
            end
         endcase
      end
   end

   assign unused_bits = ^{st_fwd[31:16], st_fwd[7:2], ca_fwd[31:16], ca_fwd[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench: two instances (FLUSH_CYCLES 1 and 3) share stimulus; expectations queued per clock.
module tb_exception_ctrl;

   typedef struct {
      logic        flush;
      logic [31:0] npc;
      logic        commit;
      logic [4:0]  code;
      logic [31:0] epc;
      logic        bd;
      logic        eret;
      logic        flush3;
      logic [31:0] npc3;
      logic        commit3;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] status_input = 32'd0;
   logic [31:0] cause_input = 32'd0;
   logic [31:0] epc_input = 32'd0;
   logic        cp0_we = 1'b0;
   logic [4:0]  cp0_addr = 5'd0;
   logic [31:0] cp0_data = 32'd0;
   logic [4:0]  flags = 5'd0;
   logic [31:0] pc = 32'd0;
   logic        ds = 1'b0;

   logic        o1_flush, o1_commit, o1_bd, o1_eret;
   logic [31:0] o1_npc, o1_epc;
   logic [4:0]  o1_code;
   logic        o3_flush, o3_commit, o3_bd, o3_eret;
   logic [31:0] o3_npc, o3_epc;
   logic [4:0]  o3_code;

   int   tests = 0;
   int   failed = 0;
   exp_t sb[$];

   always #5 clock = ~clock;

   exception_ctrl #(.EXC_VECTOR(32'h00000020), .FLUSH_CYCLES(1)) dut1 (
      .clock(clock), .reset(reset),
      .status_input(status_input), .cause_input(cause_input), .epc_input(epc_input),
      .cp0_write_enable_input(cp0_we), .cp0_write_address_input(cp0_addr),
      .cp0_write_data_input(cp0_data), .exception_flags_input(flags),
      .current_inst_address_input(pc), .is_in_delayslot_input(ds),
      .flush_output(o1_flush), .new_pc_output(o1_npc), .exc_commit_output(o1_commit),
      .exc_code_output(o1_code), .exc_epc_output(o1_epc), .exc_bd_output(o1_bd),
      .eret_output(o1_eret)
   );

   exception_ctrl #(.EXC_VECTOR(32'h00000020), .FLUSH_CYCLES(3)) dut3 (
      .clock(clock), .reset(reset),
      .status_input(status_input), .cause_input(cause_input), .epc_input(epc_input),
      .cp0_write_enable_input(cp0_we), .cp0_write_address_input(cp0_addr),
      .cp0_write_data_input(cp0_data), .exception_flags_input(flags),
      .current_inst_address_input(pc), .is_in_delayslot_input(ds),
      .flush_output(o3_flush), .new_pc_output(o3_npc), .exc_commit_output(o3_commit),
      .exc_code_output(o3_code), .exc_epc_output(o3_epc), .exc_bd_output(o3_bd),
      .eret_output(o3_eret)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t idle_e();
      exp_t e;
      e = '{default: 0};
      return e;
   endfunction

   task automatic push(input exp_t e);
      sb.push_back(e);
   endtask

   // Advance one clock and compare the DUT outputs against the oldest expectation.
   task automatic tick();
      exp_t e;
      @(posedge clock);
      #1;
      chk("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("flush",   32'(o1_flush),  32'(e.flush));
         chk("new_pc",  o1_npc,         e.npc);
         chk("commit",  32'(o1_commit), 32'(e.commit));
         chk("code",    32'(o1_code),   32'(e.code));
         chk("epc",     o1_epc,         e.epc);
         chk("bd",      32'(o1_bd),     32'(e.bd));
         chk("eret",    32'(o1_eret),   32'(e.eret));
         chk("flush3",  32'(o3_flush),  32'(e.flush3));
         chk("new_pc3", o3_npc,         e.npc3);
         chk("commit3", 32'(o3_commit), 32'(e.commit3));
         if (e.commit3) begin
            chk("code3", 32'(o3_code), 32'(e.code));
            chk("epc3",  o3_epc,       e.epc);
            chk("bd3",   32'(o3_bd),   32'(e.bd));
            chk("eret3", 32'(o3_eret), 32'(e.eret));
         end
      end
   endtask

   task automatic idle_tick();
      push(idle_e());
      tick();
   endtask

   task automatic bubble();
      flags  = 5'd0;
      pc     = 32'd0;
      ds     = 1'b0;
      cp0_we = 1'b0;
   endtask

   // One taken event followed by bubbles until the 3-cycle instance has drained.
   task automatic ev(input logic [4:0] fl, input logic [31:0] a, input logic d,
                     input logic [4:0] code, input logic [31:0] epc, input logic bd,
                     input logic er, input logic [31:0] npc);
      exp_t e;
      flags = fl;
      pc    = a;
      ds    = d;
      e = idle_e();
      e.flush = 1'b1; e.npc = npc; e.commit = 1'b1; e.code = code; e.epc = epc;
      e.bd = bd; e.eret = er; e.flush3 = 1'b1; e.npc3 = npc; e.commit3 = 1'b1;
      push(e);
      tick();
      bubble();
      for (int i = 0; i < 2; i++) begin
         e = idle_e();
         e.flush3 = 1'b1;
         e.npc3   = npc;
         push(e);
         tick();
      end
      idle_tick();
   endtask

   initial begin
      exp_t e;
      // Reset held with every flag asserted and a live PC.
      reset = 1'b0;
      flags = 5'b11111;
      pc    = 32'h100;
      for (int i = 0; i < 3; i++) idle_tick();
      bubble();
      reset = 1'b1;
      idle_tick();

      // Synchronous exceptions and priority among them.
      ev(5'b00001, 32'h100, 1'b0, 5'h08, 32'h100, 1'b0, 1'b0, 32'h20);
      ev(5'b01000, 32'h204, 1'b1, 5'h0c, 32'h200, 1'b1, 1'b0, 32'h20);
      ev(5'b01001, 32'h500, 1'b0, 5'h08, 32'h500, 1'b0, 1'b0, 32'h20);
      ev(5'b00010, 32'h600, 1'b0, 5'h0a, 32'h600, 1'b0, 1'b0, 32'h20);
      ev(5'b01100, 32'h700, 1'b0, 5'h0d, 32'h700, 1'b0, 1'b0, 32'h20);
      ev(5'b11000, 32'h704, 1'b0, 5'h0c, 32'h704, 1'b0, 1'b0, 32'h20);
      ev(5'b00001, 32'h2, 1'b1, 5'h08, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h20);

      // Interrupt: bubbles never take it.
      status_input = 32'h0000_0401;
      cause_input  = 32'h0000_0400;
      for (int i = 0; i < 3; i++) idle_tick();
      ev(5'b00000, 32'h300, 1'b0, 5'h00, 32'h300, 1'b0, 1'b0, 32'h20);

      // Same-cycle MTC0 Status with IE=0 suppresses it.
      cp0_we = 1'b1; cp0_addr = 5'd12; cp0_data = 32'd0;
      pc = 32'h300;
      idle_tick();
      bubble();
      idle_tick();

      // Pending latch alone carries the interrupt once the live request drops.
      cause_input = 32'd0;
      ev(5'b00000, 32'h340, 1'b0, 5'h00, 32'h340, 1'b0, 1'b0, 32'h20);
      idle_tick();

      // Interrupt beats syscall.
      cause_input = 32'h0000_0400;
      ev(5'b00001, 32'h360, 1'b1, 5'h00, 32'h35c, 1'b1, 1'b0, 32'h20);
      status_input = 32'd0;
      cause_input  = 32'd0;
      idle_tick();

      // ERET with same-cycle EPC write, then plain ERET.
      epc_input = 32'h400;
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_data = 32'h800;
      ev(5'b10000, 32'h380, 1'b1, 5'h00, 32'h0, 1'b0, 1'b1, 32'h800);
      ev(5'b10000, 32'h384, 1'b0, 5'h00, 32'h0, 1'b0, 1'b1, 32'h400);

      // Reset in the middle of the 3-cycle flush.
      flags = 5'b00001; pc = 32'h100; ds = 1'b0;
      e = idle_e();
      e.flush = 1'b1; e.npc = 32'h20; e.commit = 1'b1; e.code = 5'h08; e.epc = 32'h100;
      e.flush3 = 1'b1; e.npc3 = 32'h20; e.commit3 = 1'b1;
      push(e);
      tick();
      bubble();
      reset = 1'b0;
      idle_tick();
      idle_tick();
      reset = 1'b1;
      idle_tick();
      idle_tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
